// File: rtl/fp_addsub_param.sv
// Parametrised floating-point adder/subtractor (round-to-nearest-even, flush-to-zero, IEEE specials).
// Latency: fixed 5 cycles from the accepting edge to the Ready pulse; one operation in flight.
// Backpressure: none; En is accepted only in IDLE (including the Ready cycle) and ignored while Busy.
// Ports: clk/reset (sync, active-low); A, B, Op, En in; Busy, Sum, Ready, Overflow, Underflow,
// Invalid, Inexact out. Sum and flags hold from Ready to Ready; flags are cleared on accept.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic                 Op,
    input  logic                 En,
    output logic                 Busy,
    output logic [EXP_W+MAN_W:0] Sum,
    output logic                 Ready,
    output logic                 Overflow,
    output logic                 Underflow,
    output logic                 Invalid,
    output logic                 Inexact
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int XW     = MAN_W + 4;            // 1.frac + guard, round, sticky
    localparam int SW     = MAN_W + 5;            // XW plus carry
    localparam int SH_MAX = MAN_W + 3;
    localparam int LZW    = $clog2(MAN_W + 5);
    // Internal exponent must hold exp+1 and exp-lzc (possibly negative) without wrapping.
    localparam int EXW    = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [EXW-1:0] EMAX_X = EXW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]   QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;
    state_t state;

    // Stage registers; a single operation is in flight, so each stage owns its own set.
    logic [W-1:0]     a_q, b_q;
    logic             op_q;
    logic             sa_u, sb_u, spec_u, inv_u;
    logic [EXP_W-1:0] ea_u, eb_u;
    logic [MAN_W:0]   ma_u, mb_u;
    logic [W-1:0]     spec_val_u;
    logic             sx_l, sub_l;
    logic [EXP_W-1:0] ex_l;
    logic [XW-1:0]    mx_l, my_l;
    logic             sx_d, sub_d;
    logic [EXP_W-1:0] ex_d;
    logic [SW-1:0]    sum_d;
    logic             sgn_n, zero_n;
    logic [EXW-1:0]   exp_n;
    logic [XW-1:0]    man_n;

    // ---------------- UNPACK ----------------
    logic [EXP_W-1:0] ea_c, eb_c;
    logic [MAN_W-1:0] fa_c, fb_c;
    logic             sb_eff_c, a_zero_c, b_zero_c, a_nan_c, b_nan_c, a_snan_c, b_snan_c;
    logic             a_inf_c, b_inf_c, spec_c, inv_c;
    logic [W-1:0]     spec_val_c;

    always_comb begin
        ea_c       = a_q[W-2:MAN_W];
        eb_c       = b_q[W-2:MAN_W];
        fa_c       = a_q[MAN_W-1:0];
        fb_c       = b_q[MAN_W-1:0];
        sb_eff_c   = b_q[W-1] ^ op_q;
        a_zero_c   = (ea_c == '0);                 // zero or subnormal: flushed
        b_zero_c   = (eb_c == '0);
        a_nan_c    = (&ea_c) && (|fa_c);
        b_nan_c    = (&eb_c) && (|fb_c);
        a_snan_c   = a_nan_c && !fa_c[MAN_W-1];
        b_snan_c   = b_nan_c && !fb_c[MAN_W-1];
        a_inf_c    = (&ea_c) && !(|fa_c);
        b_inf_c    = (&eb_c) && !(|fb_c);
        spec_c     = 1'b0;
        inv_c      = 1'b0;
        spec_val_c = QNAN;
        if (a_nan_c || b_nan_c) begin
            spec_c = 1'b1;
            inv_c  = a_snan_c || b_snan_c;
        end else if (a_inf_c && b_inf_c && (a_q[W-1] != sb_eff_c)) begin
            spec_c = 1'b1;
            inv_c  = 1'b1;
        end else if (a_inf_c) begin
            spec_c     = 1'b1;
            spec_val_c = {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf_c) begin
            spec_c     = 1'b1;
            spec_val_c = {sb_eff_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // ---------------- ALIGN ----------------
    logic             a_ge_c, sx_c;
    logic [EXP_W-1:0] ex_c, ey_c;
    logic [MAN_W:0]   mx_c, my_c;
    logic [31:0]      diff32_c, sh32_c;
    logic [XW-1:0]    y_ext_c, y_sh_c, y_mask_c, my_al_c;

    always_comb begin
        // Tie on equal magnitude keeps A first, which gives x-x its +0 via the zero rule.
        a_ge_c   = {ea_u, ma_u} >= {eb_u, mb_u};
        ex_c     = a_ge_c ? ea_u : eb_u;
        ey_c     = a_ge_c ? eb_u : ea_u;
        mx_c     = a_ge_c ? ma_u : mb_u;
        my_c     = a_ge_c ? mb_u : ma_u;
        sx_c     = a_ge_c ? sa_u : sb_u;
        diff32_c = 32'(ex_c) - 32'(ey_c);
        sh32_c   = (diff32_c > 32'(SH_MAX)) ? 32'(SH_MAX) : diff32_c;
        y_ext_c  = {my_c, 3'b000};
        y_sh_c   = y_ext_c >> sh32_c;
        y_mask_c = ~({XW{1'b1}} << sh32_c);
        my_al_c  = {y_sh_c[XW-1:1], y_sh_c[0] | (|(y_ext_c & y_mask_c))};
    end

    // ---------------- ADD ----------------
    logic [SW-1:0] sum_c;

    always_comb begin
        if (sub_l) sum_c = {1'b0, mx_l} - {1'b0, my_l};
        else       sum_c = {1'b0, mx_l} + {1'b0, my_l};
    end

    // ---------------- NORM ----------------
    logic [LZW-1:0] lz_c;
    logic [XW-1:0]  man_c;
    logic [EXW-1:0] exp_c;
    logic           zero_c, sgn_c;

    always_comb begin
        lz_c = '0;
        for (int i = 0; i < XW; i++) begin
            if (sum_d[i]) lz_c = LZW'(XW - 1 - i);
        end
        if (sum_d[SW-1]) begin
            man_c = {sum_d[SW-1:2], sum_d[1] | sum_d[0]};
            exp_c = EXW'(ex_d) + EXW'(1);
        end else begin
            man_c = sum_d[XW-1:0] << lz_c;
            exp_c = EXW'(ex_d) - EXW'(lz_c);
        end
        zero_c = (sum_d == '0);
        // Exact zero is negative only when both inputs were negative zeros/equal-sign.
        sgn_c  = zero_c ? (sx_d & ~sub_d) : sx_d;
    end

    // ---------------- ROUND ----------------
    logic           g_c, r_c, s_c, rnd_up_c;
    logic [MAN_W+1:0] mant_c;
    logic [EXW-1:0] exp_r_c;
    logic [MAN_W-1:0] frac_c;
    logic [W-1:0]   res_c;
    logic           of_c, uf_c, inv_r_c, ix_c;

    always_comb begin
        g_c      = man_n[2];
        r_c      = man_n[1];
        s_c      = man_n[0];
        rnd_up_c = g_c & (r_c | s_c | man_n[3]);
        mant_c   = {1'b0, man_n[XW-1:3]} + (MAN_W+2)'(rnd_up_c);
        exp_r_c  = exp_n + EXW'(mant_c[MAN_W+1]);
        frac_c   = mant_c[MAN_W+1] ? mant_c[MAN_W:1] : mant_c[MAN_W-1:0];
        res_c    = {sgn_n, exp_r_c[EXP_W-1:0], frac_c};
        of_c     = 1'b0;
        uf_c     = 1'b0;
        inv_r_c  = 1'b0;
        ix_c     = g_c | r_c | s_c;
        if (spec_u) begin
            res_c   = spec_val_u;
            inv_r_c = inv_u;
            ix_c    = 1'b0;
        end else if (zero_n) begin
            res_c = {sgn_n, {(W-1){1'b0}}};
            ix_c  = 1'b0;
        end else if (exp_n[EXW-1] || exp_n == '0) begin
            res_c = {sgn_n, {(W-1){1'b0}}};
            uf_c  = 1'b1;
            ix_c  = 1'b1;
        end else if (exp_r_c >= EMAX_X) begin
            res_c = {sgn_n, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of_c  = 1'b1;
            ix_c  = 1'b1;
        end
    end

    // Datapath registers: loaded by the state that owns them, no reset needed.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (En) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= Op;
            end
            S_UNPACK: begin
                sa_u       <= a_q[W-1];
                sb_u       <= sb_eff_c;
                ea_u       <= a_zero_c ? '0 : ea_c;
                eb_u       <= b_zero_c ? '0 : eb_c;
                ma_u       <= a_zero_c ? '0 : {1'b1, fa_c};
                mb_u       <= b_zero_c ? '0 : {1'b1, fb_c};
                spec_u     <= spec_c;
                inv_u      <= inv_c;
                spec_val_u <= spec_val_c;
            end
            S_ALIGN: begin
                sx_l  <= sx_c;
                sub_l <= sa_u ^ sb_u;
                ex_l  <= ex_c;
                mx_l  <= {mx_c, 3'b000};
                my_l  <= my_al_c;
            end
            S_ADD: begin
                sx_d  <= sx_l;
                sub_d <= sub_l;
                ex_d  <= ex_l;
                sum_d <= sum_c;
            end
            S_NORM: begin
                sgn_n  <= sgn_c;
                zero_n <= zero_c;
                exp_n  <= exp_c;
                man_n  <= man_c;
            end
            default: ;
        endcase
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            Busy      <= 1'b0;
            Ready     <= 1'b0;
            Sum       <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Invalid   <= 1'b0;
            Inexact   <= 1'b0;
        end else begin
            Ready <= 1'b0;
            case (state)
                S_IDLE: if (En) begin
                    state     <= S_UNPACK;
                    Busy      <= 1'b1;
                    Overflow  <= 1'b0;
                    Underflow <= 1'b0;
                    Invalid   <= 1'b0;
                    Inexact   <= 1'b0;
                end
                S_UNPACK: state <= S_ALIGN;
                S_ALIGN:  state <= S_ADD;
                S_ADD:    state <= S_NORM;
                S_NORM:   state <= S_ROUND;
                S_ROUND: begin
                    state     <= S_IDLE;
                    Busy      <= 1'b0;
                    Ready     <= 1'b1;
                    Sum       <= res_c;
                    Overflow  <= of_c;
                    Underflow <= uf_c;
                    Invalid   <= inv_r_c;
                    Inexact   <= ix_c;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_param.sv
module tb_fp_addsub_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] A, B, Sum;
    logic        Op, En, Busy, Ready, Overflow, Underflow, Invalid, Inexact;
    logic [15:0] ha, hb, hsum;
    logic        hop, hen, hbusy, hready, hof, huf, hinv, hix;

    fp_addsub_param dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .En(En),
        .Busy(Busy), .Sum(Sum), .Ready(Ready), .Overflow(Overflow),
        .Underflow(Underflow), .Invalid(Invalid), .Inexact(Inexact)
    );

    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .A(ha), .B(hb), .Op(hop), .En(hen),
        .Busy(hbusy), .Sum(hsum), .Ready(hready), .Overflow(hof),
        .Underflow(huf), .Invalid(hinv), .Inexact(hix)
    );

    typedef struct packed { logic [31:0] sum; logic [3:0] flg; } exp_t;
    typedef struct packed { logic [15:0] sum; logic [3:0] flg; } hexp_t;
    typedef struct packed { logic [31:0] a, b; logic op; logic [31:0] s; logic [3:0] f; } vec_t;

    exp_t  sb[$];
    hexp_t hsb[$];
    int total = 0;
    int bad   = 0;
    localparam int TMO = 20;

    // Advance negedges until Ready (bounded); reports cycles since accept and whether Busy held.
    task automatic wait_ready(output int lat, output bit bok);
        lat = 0;
        bok = 1'b1;
        while (Ready !== 1'b1 && lat < TMO) begin
            if (Busy !== 1'b1) bok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; En = 1'b0; A = '0; B = '0; Op = 1'b0;
        hen = 1'b0; ha = '0; hb = '0; hop = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (Sum !== 32'h0) begin bad++; $display("FAIL reset_sum: got %h want 00000000", Sum); end
        total++; if (Ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", Ready); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        total++; if ({Overflow, Underflow, Invalid, Inexact} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {Overflow, Underflow, Invalid, Inexact});
        end
        total++; if ({hsum, hready, hbusy} !== 18'h0) begin
            bad++; $display("FAIL reset_half: got %h want 00000", {hsum, hready, hbusy});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith;
        vec_t vt[18];
        exp_t e;
        int   lat;
        bit   bok;
        // flags: {Overflow, Underflow, Invalid, Inexact}
        vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        vt[1]  = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000};
        vt[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vt[3]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000};
        vt[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vt[5]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
        vt[6]  = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b1001};
        vt[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0010};
        vt[8]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010};
        vt[9]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        vt[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
        vt[11] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
        vt[12] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
        vt[13] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0101};
        vt[14] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        vt[15] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010};
        vt[16] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001};
        vt[17] = '{32'h3FFFFFFF, 32'h33C00000, 1'b0, 32'h40000000, 4'b0001};
        for (int i = 0; i < 18; i++) begin
            A = vt[i].a; B = vt[i].b; Op = vt[i].op; En = 1'b1;
            sb.push_back('{vt[i].s, vt[i].f});
            @(negedge clk);
            En = 1'b0;
            wait_ready(lat, bok);
            total++; if (lat != 5) begin bad++; $display("FAIL arith[%0d] latency: got %0d want 5", i, lat); end
            total++; if (!bok) begin bad++; $display("FAIL arith[%0d] busy_during: got 0 want 1", i); end
            total++; if (Busy !== 1'b0) begin bad++; $display("FAIL arith[%0d] busy_at_ready: got %b want 0", i, Busy); end
            e = sb.pop_front();
            total++; if (Sum !== e.sum) begin bad++; $display("FAIL arith[%0d] sum: got %h want %h", i, Sum, e.sum); end
            total++; if ({Overflow, Underflow, Invalid, Inexact} !== e.flg) begin
                bad++; $display("FAIL arith[%0d] flags: got %b want %b", i, {Overflow, Underflow, Invalid, Inexact}, e.flg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_en;
        exp_t e;
        int   lat, extra;
        bit   bok;
        A = 32'h40000000; B = 32'h40000000; Op = 1'b0; En = 1'b1;
        sb.push_back('{32'h40800000, 4'b0000});
        @(negedge clk);
        wait_ready(lat, bok);
        En = 1'b0;
        total++; if (lat != 5) begin bad++; $display("FAIL hold latency: got %0d want 5", lat); end
        e = sb.pop_front();
        total++; if (Sum !== e.sum) begin bad++; $display("FAIL hold sum: got %h want %h", Sum, e.sum); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Ready === 1'b1 || Busy === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL hold extra_activity: got %0d want 0", extra); end
    endtask

    task automatic test_reset_midflight;
        int rdy;
        A = 32'h3F800000; B = 32'h3F800000; Op = 1'b0; En = 1'b1;
        @(negedge clk);
        En = 1'b0;
        @(negedge clk);            // operation is in ALIGN for the next edge
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            if (Ready === 1'b1) rdy++;
            @(negedge clk);
        end
        total++; if (rdy != 0) begin bad++; $display("FAIL midreset ready_count: got %0d want 0", rdy); end
        total++; if (Sum !== 32'h0) begin bad++; $display("FAIL midreset sum: got %h want 00000000", Sum); end
        total++; if ({Overflow, Underflow, Invalid, Inexact, Busy} !== 5'b0) begin
            bad++; $display("FAIL midreset flags_busy: got %b want 00000", {Overflow, Underflow, Invalid, Inexact, Busy});
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        bit   bok;
        A = 32'h3F800000; B = 32'h40400000; Op = 1'b0; En = 1'b1;
        sb.push_back('{32'h40800000, 4'b0000});
        @(negedge clk);
        En = 1'b0;
        wait_ready(lat, bok);
        e = sb.pop_front();
        total++; if (Sum !== e.sum) begin bad++; $display("FAIL b2b first_sum: got %h want %h", Sum, e.sum); end
        A = 32'h40A00000; B = 32'h40A00000; Op = 1'b0; En = 1'b1;
        sb.push_back('{32'h41200000, 4'b0000});
        @(negedge clk);
        En = 1'b0;
        wait_ready(lat, bok);
        total++; if (lat != 5) begin bad++; $display("FAIL b2b second_latency: got %0d want 5", lat); end
        e = sb.pop_front();
        total++; if (Sum !== e.sum) begin bad++; $display("FAIL b2b second_sum: got %h want %h", Sum, e.sum); end
        @(negedge clk);
    endtask

    task automatic test_half;
        logic [15:0] va[2], vb[2];
        hexp_t e;
        int lat;
        va[0] = 16'h3C00; vb[0] = 16'h4000; hsb.push_back('{16'h4200, 4'b0000});
        va[1] = 16'h7800; vb[1] = 16'h7800; hsb.push_back('{16'h7C00, 4'b1001});
        for (int i = 0; i < 2; i++) begin
            ha = va[i]; hb = vb[i]; hop = 1'b0; hen = 1'b1;
            @(negedge clk);
            hen = 1'b0;
            lat = 0;
            while (hready !== 1'b1 && lat < TMO) begin
                @(negedge clk);
                lat++;
            end
            total++; if (lat != 5) begin bad++; $display("FAIL half[%0d] latency: got %0d want 5", i, lat); end
            e = hsb.pop_front();
            total++; if (hsum !== e.sum) begin bad++; $display("FAIL half[%0d] sum: got %h want %h", i, hsum, e.sum); end
            total++; if ({hof, huf, hinv, hix} !== e.flg) begin
                bad++; $display("FAIL half[%0d] flags: got %b want %b", i, {hof, huf, hinv, hix}, e.flg);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_hold_en;
        test_reset_midflight;
        test_back_to_back;
        test_half;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
